apu_register_frontend: RTL and testbench
========================================

// Module: apu_register_frontend
// PURPOSE
//  CPU-side writer for the APU pulse channels: decodes CPU bus accesses to $4000-$4017, holds
//  pulse registers ($4000-$4007), channel enables ($4015) and frame-counter mode ($4017).
//  Emits one-cycle load strobes for each pulse channel and runs the frame sequencer that
//  generates the length, envelope and sweep clocks consumed by each pulse channel.
// PARAMETERS
//  STEP1  7457   CPU cycles to first quarter-frame event
//  STEP2  14913  CPU cycles to second event (quarter+half)
//  STEP3  22371  CPU cycles to third event (quarter)
//  STEP4  29829  4-step: quarter+half+IRQ, then wrap; 5-step: no event
//  STEP5  37281  5-step only: quarter+half, then wrap
// PORTS
//  clk            in   1   system clock
//  reset          in   1   synchronous, active-high
//  cpu_ce         in   1   one-clk enable per CPU cycle; frame counter advances only when high
//  cpu_addr       in   5   register offset from $4000 (0x00-0x17)
//  cpu_wdata      in   8   write data
//  cpu_we         in   1   write strobe, one clk per access
//  cpu_re         in   1   read strobe, one clk per access
//  cpu_rdata      out  8   read data ($4015 status only, else 0x00)
//  p1_len_nz      in   1   pulse1 length counter nonzero
//  p2_len_nz      in   1   pulse2 length counter nonzero
//  reg4000..4003  out  8   pulse1 registers (four ports)
//  reg4004..4007  out  8   pulse2 registers (four ports)
//  p1_en, p2_en   out  1   channel enables ($4015 bits 0/1)
//  p1_restart     out  1   one-clk pulse on write $4003: length load, envelope restart, duty reset
//  p2_restart     out  1   same for $4007
//  p1_sweep_rld   out  1   one-clk pulse on write $4001
//  p2_sweep_rld   out  1   one-clk pulse on write $4005
//  quarter_clk    out  1   one-clk pulse: envelope clock (iEnvelope_clk)
//  half_clk       out  1   one-clk pulse: length+sweep clock (iLength_clk, iSweep_clk)
//  frame_irq      out  1   frame interrupt flag, level
// BEHAVIOUR
//  Reset: all regs, enables, strobes, quarter/half_clk, frame_irq, cpu_rdata = 0; mode=4-step,
//   irq_inhibit=0, frame count=0.
//  Writes: register updates visible at outputs the clk after cpu_we; strobes assert that same
//   clk for exactly one cycle. Unmapped offsets (0x08-0x14, 0x16) ignored.
//  $4015 write: p1_en=wdata[0], p2_en=wdata[1]; other bits ignored.
//  $4015 read: cpu_rdata registered, valid clk after cpu_re:
//   {1'b0, frame_irq, 4'b0, p2_len_nz, p1_len_nz}; read clears frame_irq next clk.
//  $4017 write: mode=wdata[7] (1=5-step), irq_inhibit=wdata[6]; inhibit=1 clears frame_irq;
//   frame count reset to 0; if wdata[7]=1, quarter_clk and half_clk pulse next clk.
//  Frame counter: 16-bit, increments on cpu_ce; events fire on the clk the count reaches value:
//   STEP1 Q; STEP2 Q+H; STEP3 Q; STEP4: 4-step Q+H, set frame_irq unless inhibited, wrap to 0;
//   5-step nothing; STEP5 (5-step) Q+H, wrap to 0. Count never exceeds active terminal value.
//  Simultaneous: IRQ set and $4015 read same clk -> set wins, flag stays 1, rdata shows old
//   value. $4017 write with frame event same clk -> write wins, event suppressed.
//  Strobes and Q/H pulses never exceed one clk, even if cpu_ce held high.
//  Reset mid-frame returns count to 0, no pending pulses emitted.
// TESTING
//  1 Write $4003=0xF9 -> reg4003=0xF9 next clk, p1_restart one clk, p2_restart stays 0.
//  2 cpu_ce always 1, 4-step: Q at 7457, Q+H at 14913, Q at 22371, Q+H+frame_irq at 29829,
//    wrap; next Q at count 7457 of second frame.
//  3 Write $4017=0x80 -> Q+H pulse next clk; subsequent events at 7457/14913/22371/37281;
//    frame_irq never set.
//  4 frame_irq=1, p1_len_nz=1, read $4015 -> rdata=0x41, frame_irq=0 following clk.
//  5 Write $4017=0x40 while frame_irq=1 -> irq cleared; full 4-step frame -> irq stays 0.
//  6 Reset asserted at count 20000 -> all outputs 0; next Q exactly 7457 cpu_ce after release.

Source files
------------

// File: rtl/apu_register_frontend.sv
// apu_register_frontend: CPU register decode and pulse-channel strobes
// for the APU, plus the 4/5-step frame sequencer (quarter/half clocks, IRQ).
module apu_register_frontend #(
  parameter logic [15:0] STEP1 = 16'd7457,
  parameter logic [15:0] STEP2 = 16'd14913,
  parameter logic [15:0] STEP3 = 16'd22371,
  parameter logic [15:0] STEP4 = 16'd29829,
  parameter logic [15:0] STEP5 = 16'd37281
) (
  input  logic       i_clk,
  input  logic       i_reset,
  input  logic       i_cpu_ce,
  input  logic [4:0] i_cpu_addr,
  input  logic [7:0] i_cpu_wdata,
  input  logic       i_cpu_we,
  input  logic       i_cpu_re,
  output logic [7:0] o_cpu_rdata,
  input  logic       i_p1_len_nz,
  input  logic       i_p2_len_nz,
  output logic [7:0] o_reg4000,
  output logic [7:0] o_reg4001,
  output logic [7:0] o_reg4002,
  output logic [7:0] o_reg4003,
  output logic [7:0] o_reg4004,
  output logic [7:0] o_reg4005,
  output logic [7:0] o_reg4006,
  output logic [7:0] o_reg4007,
  output logic       o_p1_en,
  output logic       o_p2_en,
  output logic       o_p1_restart,
  output logic       o_p2_restart,
  output logic       o_p1_sweep_rld,
  output logic       o_p2_sweep_rld,
  output logic       o_quarter_clk,
  output logic       o_half_clk,
  output logic       o_frame_irq
);
  logic [7:0]  r_reg [8];
  logic [7:0]  r_rdata;
  logic [15:0] r_count;
  logic        r_mode;
  logic        r_inhibit;
  logic        r_irq;
  logic        r_p1_en;
  logic        r_p2_en;
  logic        r_p1_restart;
  logic        r_p2_restart;
  logic        r_p1_sweep;
  logic        r_p2_sweep;
  logic        r_quarter;
  logic        r_half;

  logic [15:0] w_inc;
  logic [15:0] w_term;
  logic        w_wr_reg;
  logic        w_wr_status;
  logic        w_wr_frame;
  logic        w_rd_status;
  logic        w_step;
  logic        w_wrap;
  logic        w_q;
  logic        w_h;
  logic        w_irq_set;

  always_comb begin
    w_wr_reg    = i_cpu_we && (i_cpu_addr < 5'h08);
    w_wr_status = i_cpu_we && (i_cpu_addr == 5'h15);
    w_wr_frame  = i_cpu_we && (i_cpu_addr == 5'h17);
    w_rd_status = i_cpu_re && (i_cpu_addr == 5'h15);
    w_inc       = r_count + 16'd1;
    w_term      = r_mode ? STEP5 : STEP4;
    // A $4017 write owns the counter this clk, so it masks any event
    w_step      = i_cpu_ce && !w_wr_frame;
    w_wrap      = w_step && (w_inc == w_term);
    w_h         = w_wrap || (w_step && (w_inc == STEP2));
    w_q         = w_h || (w_step && ((w_inc == STEP1) || (w_inc == STEP3)));
    w_irq_set   = w_wrap && !r_mode && !r_inhibit;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      for (int i = 0; i < 8; i++) r_reg[i] <= 8'h00;
      r_rdata      <= 8'h00;
      r_count      <= 16'd0;
      r_mode       <= 1'b0;
      r_inhibit    <= 1'b0;
      r_irq        <= 1'b0;
      r_p1_en      <= 1'b0;
      r_p2_en      <= 1'b0;
      r_p1_restart <= 1'b0;
      r_p2_restart <= 1'b0;
      r_p1_sweep   <= 1'b0;
      r_p2_sweep   <= 1'b0;
      r_quarter    <= 1'b0;
      r_half       <= 1'b0;
    end else begin
      if (w_wr_reg) r_reg[i_cpu_addr[2:0]] <= i_cpu_wdata;
      if (w_wr_status) begin
        r_p1_en <= i_cpu_wdata[0];
        r_p2_en <= i_cpu_wdata[1];
      end
      r_p1_restart <= i_cpu_we && (i_cpu_addr == 5'h03);
      r_p2_restart <= i_cpu_we && (i_cpu_addr == 5'h07);
      r_p1_sweep   <= i_cpu_we && (i_cpu_addr == 5'h01);
      r_p2_sweep   <= i_cpu_we && (i_cpu_addr == 5'h05);
      if (i_cpu_re) begin
        r_rdata <= w_rd_status
          ? {1'b0, r_irq, 4'b0000, i_p2_len_nz, i_p1_len_nz}
          : 8'h00;
      end
      if (w_wr_frame) begin
        r_mode    <= i_cpu_wdata[7];
        r_inhibit <= i_cpu_wdata[6];
        r_count   <= 16'd0;
        r_quarter <= i_cpu_wdata[7];
        r_half    <= i_cpu_wdata[7];
      end else begin
        r_quarter <= w_q;
        r_half    <= w_h;
        if (i_cpu_ce) r_count <= w_wrap ? 16'd0 : w_inc;
      end
      // Setting wins over a same-clk status read
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (w_rd_status || (w_wr_frame && i_cpu_wdata[6])) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign o_reg4000      = r_reg[0];
  assign o_reg4001      = r_reg[1];
  assign o_reg4002      = r_reg[2];
  assign o_reg4003      = r_reg[3];
  assign o_reg4004      = r_reg[4];
  assign o_reg4005      = r_reg[5];
  assign o_reg4006      = r_reg[6];
  assign o_reg4007      = r_reg[7];
  assign o_cpu_rdata    = r_rdata;
  assign o_p1_en        = r_p1_en;
  assign o_p2_en        = r_p2_en;
  assign o_p1_restart   = r_p1_restart;
  assign o_p2_restart   = r_p2_restart;
  assign o_p1_sweep_rld = r_p1_sweep;
  assign o_p2_sweep_rld = r_p2_sweep;
  assign o_quarter_clk  = r_quarter;
  assign o_half_clk     = r_half;
  assign o_frame_irq    = r_irq;
endmodule

// File: tb/tb_apu_register_frontend.sv
// tb_apu_register_frontend: directed frame-sequencer scenarios plus random
// bus traffic, checked every cycle against a behavioural model.
module tb_apu_register_frontend;
  localparam int S1 = 745;
  localparam int S2 = 1491;
  localparam int S3 = 2237;
  localparam int S4 = 2982;
  localparam int S5 = 3728;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, ce, we, re, p1nz, p2nz;
  logic [4:0] addr;
  logic [7:0] wdata;
  logic [7:0] rdata;
  logic [7:0] d_reg [8];
  logic       p1en, p2en, p1r, p2r, p1s, p2s, qclk, hclk, irq;

  apu_register_frontend #(
    .STEP1(16'(S1)), .STEP2(16'(S2)), .STEP3(16'(S3)),
    .STEP4(16'(S4)), .STEP5(16'(S5))
  ) dut (
    .i_clk(clk), .i_reset(reset), .i_cpu_ce(ce),
    .i_cpu_addr(addr), .i_cpu_wdata(wdata),
    .i_cpu_we(we), .i_cpu_re(re), .o_cpu_rdata(rdata),
    .i_p1_len_nz(p1nz), .i_p2_len_nz(p2nz),
    .o_reg4000(d_reg[0]), .o_reg4001(d_reg[1]),
    .o_reg4002(d_reg[2]), .o_reg4003(d_reg[3]),
    .o_reg4004(d_reg[4]), .o_reg4005(d_reg[5]),
    .o_reg4006(d_reg[6]), .o_reg4007(d_reg[7]),
    .o_p1_en(p1en), .o_p2_en(p2en),
    .o_p1_restart(p1r), .o_p2_restart(p2r),
    .o_p1_sweep_rld(p1s), .o_p2_sweep_rld(p2s),
    .o_quarter_clk(qclk), .o_half_clk(hclk),
    .o_frame_irq(irq)
  );

  int n_chk = 0;
  int n_fail = 0;
  bit chk_on = 0;

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Model: frame position counted in cpu_ce ticks since the frame began
  logic [7:0] m_reg [8];
  logic [7:0] e_rdata;
  logic       m_en1, m_en2, m_irq, m_mode, m_inh;
  logic       e_p1r, e_p2r, e_p1s, e_p2s, e_q, e_h;
  int         m_pos;

  always @(posedge clk) begin : model
    int pos;
    int term;
    logic irq_n, mode, inh, q, h, set, clr;
    logic [7:0] rd;
    pos = m_pos; irq_n = m_irq; mode = m_mode; inh = m_inh;
    rd = e_rdata; q = 0; h = 0; set = 0; clr = 0;
    if (reset) begin
      pos = 0; irq_n = 0; mode = 0; inh = 0; rd = 8'h00;
      for (int k = 0; k < 8; k++) m_reg[k] <= 8'h00;
      m_en1 <= 0; m_en2 <= 0;
      e_p1r <= 0; e_p2r <= 0; e_p1s <= 0; e_p2s <= 0;
    end else begin
      if (we && addr < 8) m_reg[addr[2:0]] <= wdata;
      if (we && addr == 5'h15) begin
        m_en1 <= wdata[0];
        m_en2 <= wdata[1];
      end
      e_p1r <= we && addr == 5'h03;
      e_p2r <= we && addr == 5'h07;
      e_p1s <= we && addr == 5'h01;
      e_p2s <= we && addr == 5'h05;
      if (re) rd = (addr == 5'h15) ? {2'b00, m_irq, 3'b000, p2nz, p1nz} >> 0 : 8'h00;
      if (re && addr == 5'h15) begin
        rd = 8'h00;
        rd[6] = m_irq; rd[1] = p2nz; rd[0] = p1nz;
        clr = 1;
      end
      if (we && addr == 5'h17) begin
        mode = wdata[7]; inh = wdata[6]; pos = 0;
        q = wdata[7]; h = wdata[7];
        if (wdata[6]) clr = 1;
      end else if (ce) begin
        pos++;
        term = mode ? S5 : S4;
        if (pos == S1 || pos == S3) q = 1;
        if (pos == S2) begin q = 1; h = 1; end
        if (pos == term) begin
          q = 1; h = 1; set = !mode && !inh; pos = 0;
        end
      end
      if (set) irq_n = 1;
      else if (clr) irq_n = 0;
    end
    m_pos <= pos; m_irq <= irq_n; m_mode <= mode; m_inh <= inh;
    e_rdata <= rd; e_q <= q; e_h <= h;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      for (int k = 0; k < 8; k++)
        cmp($sformatf("reg400%0d", k), d_reg[k], m_reg[k]);
      cmp("rdata", rdata, e_rdata);
      cmp("p1_en", p1en, m_en1);
      cmp("p2_en", p2en, m_en2);
      cmp("p1_restart", p1r, e_p1r);
      cmp("p2_restart", p2r, e_p2r);
      cmp("p1_sweep_rld", p1s, e_p1s);
      cmp("p2_sweep_rld", p2s, e_p2s);
      cmp("quarter_clk", qclk, e_q);
      cmp("half_clk", hclk, e_h);
      cmp("frame_irq", irq, m_irq);
    end
  end

  int ql[$];
  int hl[$];
  int irq_first;
  logic [7:0] rd_a, rd_b;

  task automatic wr(input logic [4:0] a, input logic [7:0] d);
    we = 1; re = 0; addr = a; wdata = d;
    @(negedge clk);
    we = 0;
  endtask

  // ce held high; ql/hl log the tick index of every quarter/half pulse
  task automatic run(input int n, input int ka, input int kb);
    ql.delete(); hl.delete(); irq_first = -1;
    for (int k = 1; k <= n; k++) begin
      ce = 1; we = 0; addr = 5'h15;
      re = (k == ka) || (k == kb);
      @(negedge clk);
      if (qclk) ql.push_back(k);
      if (hclk) hl.push_back(k);
      if (irq && irq_first < 0) irq_first = k;
      if (k == ka) rd_a = rdata;
      if (k == kb) rd_b = rdata;
    end
    re = 0;
  endtask

  task automatic cmp_log(input string nm, input int got[$], input int n,
                         input int e0, input int e1, input int e2,
                         input int e3, input int e4);
    int e [5];
    bit ok;
    e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3; e[4] = e4;
    ok = (got.size() == n);
    for (int i = 0; ok && i < n; i++) ok = (got[i] == e[i]);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d events first %0d, expected %0d events first %0d",
               nm, got.size(), (got.size() > 0) ? got[0] : -1, n, e0);
    end
  endtask

  initial begin
    reset = 1; ce = 0; we = 0; re = 0; addr = 0; wdata = 0;
    p1nz = 0; p2nz = 0;
    @(negedge clk); @(negedge clk);
    chk_on = 1;
    cmp("rst_rdata", rdata, 0);
    cmp("rst_irq", irq, 0);
    cmp("rst_quarter", qclk, 0);
    cmp("rst_reg4003", d_reg[3], 0);
    reset = 0;

    wr(5'h03, 8'hF9);
    cmp("t1_reg4003", d_reg[3], 8'hF9);
    cmp("t1_p1_restart", p1r, 1);
    cmp("t1_p2_restart", p2r, 0);
    @(negedge clk);
    cmp("t1_restart_one_clk", p1r, 0);
    wr(5'h05, 8'h5A);
    cmp("sweep2_strobe", p2s, 1);
    wr(5'h15, 8'hFE);
    cmp("en_p1", p1en, 0);
    cmp("en_p2", p2en, 1);
    wr(5'h0A, 8'h77);

    ce = 1;
    wr(5'h17, 8'h00);
    run(2000, 0, 0);
    reset = 1;
    @(negedge clk);
    cmp("t6_reg4003", d_reg[3], 0);
    cmp("t6_p2_en", p2en, 0);
    cmp("t6_quarter", qclk, 0);
    reset = 0;

    p1nz = 1; p2nz = 0;
    run(S4 + S1, S4, S4 + 5);
    cmp_log("t2_quarter", ql, 5, S1, S2, S3, S4, S4 + S1);
    cmp_log("t2_half", hl, 2, S2, S4, 0, 0, 0);
    cmp("t2_irq_at", irq_first, S4);
    cmp("rd_same_clk_as_set", rd_a, 8'h01);
    cmp("t4_rdata", rd_b, 8'h41);
    cmp("t4_irq_cleared", irq, 0);

    run(S4 - S1, 0, 0);
    cmp("t5_irq_before", irq, 1);
    wr(5'h17, 8'h40);
    cmp("t5_irq_cleared", irq, 0);
    cmp("t5_no_quarter", qclk, 0);
    run(S4 + S1, 0, 0);
    cmp_log("t5_quarter", ql, 5, S1, S2, S3, S4, S4 + S1);
    cmp("t5_irq_never", irq_first, -1);

    wr(5'h17, 8'h00);
    run(S1 - 1, 0, 0);
    wr(5'h17, 8'h00);
    cmp("write_masks_event", qclk, 0);
    run(S1, 0, 0);
    cmp_log("after_mask", ql, 1, S1, 0, 0, 0, 0);

    wr(5'h17, 8'h80);
    cmp("t3_quarter_now", qclk, 1);
    cmp("t3_half_now", hclk, 1);
    run(S5 + S1, 0, 0);
    cmp_log("t3_quarter", ql, 5, S1, S2, S3, S5, S5 + S1);
    cmp_log("t3_half", hl, 2, S2, S5, 0, 0, 0);
    cmp("t3_irq_never", irq_first, -1);

    for (int c = 0; c < 20000; c++) begin
      reset = ($urandom_range(0, 2999) == 0);
      ce = ($urandom_range(0, 3) != 0);
      addr = 5'($urandom_range(0, 23));
      wdata = 8'($urandom);
      we = ($urandom_range(0, 3) == 0);
      re = ($urandom_range(0, 3) == 0);
      if (addr == 5'h17 && $urandom_range(0, 63) != 0) we = 0;
      p1nz = 1'($urandom);
      p2nz = 1'($urandom);
      @(negedge clk);
    end
    reset = 0; we = 0; re = 0;
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end
endmodule
